muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_signfix.sv | 24 ++
 rtl/muldiv_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
//
// Contents: sequencer state enum, op codes, ALU control codes, last iteration index.

package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEG_IN  = 3'd1,
        S_CALC    = 3'd2,
        S_NEG_OUT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [2:0] ALU_CTL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTL_SUB = 3'b110;

    localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - combinational conditional two's-complement negators
//
// Ports:
//   a_in/a_neg -> a_out : 32-bit conditional negate
//   b_in/b_neg -> b_out : 32-bit conditional negate
//   p_in/p_neg -> p_out : 64-bit conditional negate

module muldiv_signfix (
    input  logic [31:0] a_in,
    input  logic        a_neg,
    output logic [31:0] a_out,
    input  logic [31:0] b_in,
    input  logic        b_neg,
    output logic [31:0] b_out,
    input  logic [63:0] p_in,
    input  logic        p_neg,
    output logic [63:0] p_out
);

    assign a_out = a_neg ? (~a_in + 32'd1) : a_in;
    assign b_out = b_neg ? (~b_in + 32'd1) : b_in;
    assign p_out = p_neg ? (~p_in + 64'd1) : p_in;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/DIV sequencer borrowing the EX-stage ALU
//
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV via NEG_IN/NEG_OUT).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, op, src_a/b  : issue request, operation, operands
//   busy, done          : pipeline stall, one-cycle completion pulse
//   alu_own/ctl/a/b     : EX ALU mux select and operand/control drive
//   alu_result/cout     : ALU sum/difference and bit-31 carry-out
//   hi, lo              : HI/LO result registers

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic            alu_own,
    output logic [2:0]      alu_ctl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_cout,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            own_q, own_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    // Divide works on {acc,q} shifted left by one before the trial subtract.
    logic [XLEN-1:0] acc_sh;
    assign acc_sh = {acc_q[XLEN-2:0], q_q[XLEN-1]};

`ifdef MULDIV_SIGNED_EN
    logic            signed_q, signed_d;
    logic            sgn_a_q, sgn_a_d;
    logic            sgn_b_q, sgn_b_d;
    logic [XLEN-1:0] fix_a_in, fix_a_out, fix_b_in, fix_b_out;
    logic            fix_a_neg, fix_b_neg;
    logic [2*XLEN-1:0] fix_p_out;

    // NEG_IN takes magnitudes of q (dividend/multiplicand) and m; NEG_OUT
    // reuses the same negators for quotient (a) and remainder (b).
    always_comb begin
        fix_a_in  = q_q;
        fix_b_in  = acc_q;
        fix_a_neg = sgn_a_q ^ sgn_b_q;
        fix_b_neg = sgn_a_q;
        if (state_q == S_NEG_IN) begin
            fix_b_in  = m_q;
            fix_a_neg = sgn_a_q;
            fix_b_neg = sgn_b_q;
        end
    end

    muldiv_signfix u_signfix (
        .a_in  (fix_a_in),
        .a_neg (fix_a_neg),
        .a_out (fix_a_out),
        .b_in  (fix_b_in),
        .b_neg (fix_b_neg),
        .b_out (fix_b_out),
        .p_in  ({acc_q, q_q}),
        .p_neg (sgn_a_q ^ sgn_b_q),
        .p_out (fix_p_out)
    );
`else
    logic unused_op_hi;
    assign unused_op_hi = op[1];
`endif

    // ALU drive is combinational from registers; zero whenever not owned.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = 3'b000;
        if (own_q) begin
            if (is_div_q) begin
                alu_a   = acc_sh;
                alu_b   = m_q;
                alu_ctl = ALU_CTL_SUB;
            end else begin
                alu_a   = acc_q;
                alu_b   = q_q[0] ? m_q : '0;
                alu_ctl = ALU_CTL_ADD;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_SIGNED_EN
        signed_d = signed_q;
        sgn_a_d  = sgn_a_q;
        sgn_b_d  = sgn_b_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    acc_d    = '0;
                    q_d      = src_a;
                    m_d      = src_b;
                    cnt_d    = '0;
                    is_div_d = op[0];
`ifdef MULDIV_SIGNED_EN
                    signed_d = op[1];
                    sgn_a_d  = op[1] & src_a[XLEN-1];
                    sgn_b_d  = op[1] & src_b[XLEN-1];
                    state_d  = op[1] ? S_NEG_IN : S_CALC;
`else
                    state_d  = S_CALC;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_NEG_IN: begin
                q_d     = fix_a_out;
                m_d     = fix_b_out;
                state_d = S_CALC;
            end
            S_NEG_OUT: begin
                if (is_div_q) begin
                    q_d   = fix_a_out;
                    acc_d = fix_b_out;
                end else begin
                    {acc_d, q_d} = fix_p_out;
                end
                state_d = S_DONE;
            end
`endif
            S_CALC: begin
                if (is_div_q) begin
                    // Shifted-out bit set means the partial remainder already
                    // exceeds m, so the subtract is taken regardless of borrow.
                    if (acc_q[XLEN-1] | alu_cout) begin
                        acc_d = alu_result;
                        q_d   = {q_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = acc_sh;
                        q_d   = {q_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {alu_cout, alu_result[XLEN-1:1]};
                    q_d   = {alu_result[0], q_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == ITER_LAST) begin
`ifdef MULDIV_SIGNED_EN
                    state_d = signed_q ? S_NEG_OUT : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // DONE is only entered from CALC or NEG_OUT, so this is the entry edge.
        if (state_d == S_DONE) begin
            hi_d = acc_d;
            lo_d = q_d;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        own_d  = (state_d == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            own_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
            signed_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            own_q    <= own_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_SIGNED_EN
            signed_q <= signed_d;
            sgn_a_q  <= sgn_a_d;
            sgn_b_q  <= sgn_b_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_own = own_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with a behavioural ALU

module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
    localparam int SIGNED_LAT = 35;
`else
    localparam int SIGNED_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    wire         busy, done, alu_own, alu_cout;
    wire  [2:0]  alu_ctl;
    wire  [31:0] alu_a, alu_b, alu_result, hi, lo;

    always #5 clk = ~clk;

    // EX-stage ALU: 33-bit add, or add of inverted B plus one for subtract.
    wire [32:0] alu_sum = (alu_ctl == 3'b110) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                              : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_result = alu_sum[31:0];
    assign alu_cout   = alu_sum[32];

    muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .alu_own    (alu_own),
        .alu_ctl    (alu_ctl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .hi         (hi),
        .lo         (lo)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result {hi,lo} from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma, mb, qq, rr;
        longint      sp;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`endif
        if (!o[0]) begin
            if (sgn) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            return {32'd0, a} * {32'd0, b};
        end
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        if (mb == 0) begin
            qq = 32'hFFFF_FFFF;
            rr = ma;
        end else begin
            qq = ma / mb;
            rr = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) qq = 32'd0 - qq;
        if (sgn && a[31])           rr = 32'd0 - rr;
        return {rr, qq};
    endfunction

    // Issues one op in the current cycle (cycle 0) and runs until done.
    // poke > 0 raises start with junk inputs during that cycle of the op.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [63:0] res, output int lat,
                          output int own_cnt, output int bad);
        bad = 0;
        own_cnt = 0;
        start = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        lat = 1;
        while (!done && lat < 60) begin
            if (!busy) bad++;
            if (alu_own) begin
                own_cnt++;
                if (alu_ctl !== (o[0] ? 3'b110 : 3'b010)) bad++;
            end else if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctl !== 3'd0) begin
                bad++;
            end
            start = (lat == poke);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (busy || alu_own || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctl !== 3'd0) bad++;
        res = {hi, lo};
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] res;
        int lat, own_cnt, bad, seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33});
        vecs.push_back('{2'b01, 32'd100,       32'd7,         32'd2,         32'd14,         33});
        vecs.push_back('{2'b01, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33});
        vecs.push_back('{2'b00, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         33});
        vecs.push_back('{2'b01, 32'd5,         32'd10,        32'd5,         32'd0,         33});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33});
        vecs.push_back('{2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         33});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 35});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 35});
        vecs.push_back('{2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         35});
`else
        vecs.push_back('{2'b10, 32'd3,         32'd5,         32'd0,         32'd15,        33});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 33});
`endif

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_ctl", {59'd0, busy, done, alu_own, 2'b00} | {61'd0, alu_ctl}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_alu_ab", {alu_a, alu_b}, 64'd0);

        // Directed vectors, issued back-to-back from each DONE cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, own_cnt, bad);
            chk($sformatf("vec%0d_hilo", i), res, {vecs[i].hi, vecs[i].lo});
            chk_int($sformatf("vec%0d_done_cycle", i), lat, vecs[i].lat);
            chk_int($sformatf("vec%0d_own_cycles", i), own_cnt, 32);
            chk_int($sformatf("vec%0d_handshake_errs", i), bad, 0);
        end

        // start pulsed in cycle 5 must be ignored.
        run_op(2'b01, 32'd100, 32'd7, 5, res, lat, own_cnt, bad);
        chk("poke_hilo", res, {32'd2, 32'd14});
        chk_int("poke_done_cycle", lat, 33);
        chk_int("poke_handshake_errs", bad, 0);
        // One idle cycle follows so the next op starts from IDLE.
        @(posedge clk); #1;
        chk("idle_after_done", {62'd0, done, busy}, 64'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(0, 20);
                1: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb, 0, res, lat, own_cnt, bad);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), res, ref_model(ro, ra, rb));
            chk_int($sformatf("rnd%0d_done_cycle", i), lat, ro[1] ? SIGNED_LAT : 33);
            chk_int($sformatf("rnd%0d_handshake_errs", i), bad, 0);
        end

        // Reset during CALC iteration 10 discards the op and clears outputs.
        start = 1'b1;
        op = 2'b00;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_ctl", {59'd0, busy, done, alu_own, 2'b00} | {61'd0, alu_ctl}, 64'd0);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk_int("midreset_stays_idle", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
